// File: rtl/fwd_hazard_scoreboard_if.sv
// Bundle between the ID stage and the forwarding/hazard scoreboard.
// master = pipeline side, slave = scoreboard side.
interface fwd_hazard_scoreboard_if #(
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 3,
    parameter int W       = 32,
    parameter int LATW    = 2,
    parameter int SELW    = $clog2(DEPTH + 1)
);
    logic                    id_valid;
    logic                    id_wr;
    logic [4:0]              id_dst;
    logic [LATW-1:0]         id_ready_lat;
    logic                    flush;
    logic [5*NUM_SRC-1:0]    id_src;
    logic [W*NUM_SRC-1:0]    id_src_data;
    logic [W*DEPTH-1:0]      stage_data;
    logic                    stall_out;
    logic [SELW*NUM_SRC-1:0] src_sel;
    logic [W*NUM_SRC-1:0]    src_fwd;
    logic [31:0]             stall_cnt;
    logic [31:0]             fwd_cnt;

    modport master (
        output id_valid, id_wr, id_dst, id_ready_lat, flush,
        output id_src, id_src_data, stage_data,
        input  stall_out, src_sel, src_fwd, stall_cnt, fwd_cnt
    );

    modport slave (
        input  id_valid, id_wr, id_dst, id_ready_lat, flush,
        input  id_src, id_src_data, stage_data,
        output stall_out, src_sel, src_fwd, stall_cnt, fwd_cnt
    );
endinterface

// File: rtl/fwd_hazard_scoreboard.sv
// Shadow pipeline of in-flight writers: forward selects/data and load-use stall.
// Optional FWD_STATS_EN adds saturating stall/forward counters.
module fwd_hazard_scoreboard #(
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 3,
    parameter int W       = 32,
    parameter int LATW    = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    fwd_hazard_scoreboard_if.slave   bus
);
    localparam int SELW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic            v;
        logic [4:0]      dst;
        logic [LATW-1:0] lat;
    } entry_t;

    entry_t [DEPTH-1:0]      ent_q;
    entry_t [DEPTH-1:0]      ent_d;
    logic [NUM_SRC-1:0]      hit;
    logic [NUM_SRC-1:0]      need_stall;
    logic [SELW*NUM_SRC-1:0] sel;
    logic [W*NUM_SRC-1:0]    fwd;
    logic                    stall;
    logic                    push;
    logic [31:0]             fwd_add;

    // Smallest matching k is the youngest writer, so it shadows older ones.
    always_comb begin
        hit        = '0;
        need_stall = '0;
        sel        = '0;
        fwd        = bus.id_src_data;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (!hit[i] && ent_q[k].v
                    && ent_q[k].dst == bus.id_src[i*5 +: 5]
                    && bus.id_src[i*5 +: 5] != 5'd0) begin
                    hit[i] = 1'b1;
                    if (k >= int'(ent_q[k].lat)) begin
                        sel[i*SELW +: SELW] = SELW'(k + 1);
                        fwd[i*W +: W]       = bus.stage_data[k*W +: W];
                    end else begin
                        need_stall[i] = 1'b1;
                    end
                end
            end
        end
    end

    assign stall = bus.id_valid & (|need_stall);
    assign push  = bus.id_valid & bus.id_wr & (bus.id_dst != 5'd0)
                 & ~stall & ~bus.flush;

    always_comb begin
        ent_d    = '0;
        ent_d[0] = push ? {1'b1, bus.id_dst, bus.id_ready_lat} : '0;
        for (int k = 1; k < DEPTH; k++) begin
            ent_d[k] = ent_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ent_q <= '0;
        end else begin
            ent_q <= ent_d;
        end
    end

    always_comb begin
        fwd_add = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (sel[i*SELW +: SELW] != '0) begin
                fwd_add = fwd_add + 32'd1;
            end
        end
    end

`ifdef FWD_STATS_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;
    logic [31:0] fwd_cnt_q;
    logic [31:0] fwd_cnt_d;
    logic [32:0] fwd_sum;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        fwd_cnt_d   = fwd_cnt_q;
        fwd_sum     = {1'b0, fwd_cnt_q} + {1'b0, fwd_add};
        if (stall && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (!stall && bus.id_valid) begin
            fwd_cnt_d = fwd_sum[32] ? 32'hFFFF_FFFF : fwd_sum[31:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
    assign bus.fwd_cnt   = fwd_cnt_q;
`else
    logic unused_add;
    assign unused_add    = ^fwd_add;
    assign bus.stall_cnt = '0;
    assign bus.fwd_cnt   = '0;
`endif

    assign bus.stall_out = stall;
    assign bus.src_sel   = sel;
    assign bus.src_fwd   = fwd;
endmodule
